matcher: RTL and testbench

MATCHER -- requirements
Module: matcher

---
 rtl/matcher.sv | 155 +++++++++++++++
 tb/tb_matcher.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/matcher.sv
// Vocabulary matcher: scans a window of an internal register-file vocabulary for a word.
// Optional macro MATCHER_NULL_TERM_EN makes an all-zero entry terminate the scan.
module matcher #(
   parameter int ADDR_WIDTH  = 4,
   parameter int WORD_LENGTH = 3,
   parameter int DATA_WIDTH  = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [WORD_LENGTH*DATA_WIDTH-1:0]   word,
   input  logic [ADDR_WIDTH-1:0]               start_addr,
   input  logic [ADDR_WIDTH-1:0]               end_addr,
   input  logic                                vocab_we,
   input  logic [ADDR_WIDTH-1:0]               vocab_waddr,
   input  logic [WORD_LENGTH*DATA_WIDTH-1:0]   vocab_wdata,
   output logic [ADDR_WIDTH-1:0]               curr_addr,
   output logic                                match,
   output logic [ADDR_WIDTH-1:0]               match_addr,
   output logic                                vocab_overflow,
   output logic                                nullptr_vocab,
   output logic                                done
);

   localparam int W     = WORD_LENGTH * DATA_WIDTH;
   localparam int DEPTH = 1 << ADDR_WIDTH;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SCAN  = 2'd1;
   localparam logic [1:0] S_FOUND = 2'd2;
   localparam logic [1:0] S_MISS  = 2'd3;

   logic [W-1:0]          vocab_q [DEPTH];
   logic [W-1:0]          vocab_d [DEPTH];
   logic [W-1:0]          word_q, word_d;
   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] curr_addr_q, curr_addr_d;
   logic [ADDR_WIDTH-1:0] match_addr_q, match_addr_d;
   logic                  match_q, match_d;
   logic                  overflow_q, overflow_d;
   logic                  null_q, null_d;
   logic                  done_q, done_d;

   logic                  trigger_s;
   logic [W-1:0]          rd_entry_s;
   logic                  entry_null_s;

   assign trigger_s  = (word != word_q) || vocab_we;
   assign rd_entry_s = vocab_q[curr_addr_q];

`ifdef MATCHER_NULL_TERM_EN
   assign entry_null_s = (rd_entry_s == {W{1'b0}});
`else
   assign entry_null_s = 1'b0;
`endif

   // Vocabulary next-state: single write port, all other entries hold.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         if (vocab_we && (vocab_waddr == ADDR_WIDTH'(i))) begin
            vocab_d[i] = vocab_wdata;
         end else begin
            vocab_d[i] = vocab_q[i];
         end
      end
   end

   // Scan controller: a trigger restarts the scan and outranks any SCAN decision.
   always_comb begin
      word_d       = word_q;
      state_d      = state_q;
      curr_addr_d  = curr_addr_q;
      match_addr_d = match_addr_q;
      match_d      = match_q;
      overflow_d   = overflow_q;
      null_d       = null_q;
      done_d       = done_q;

      if (trigger_s) begin
         word_d       = word;
         state_d      = S_SCAN;
         curr_addr_d  = start_addr;
         match_addr_d = {ADDR_WIDTH{1'b0}};
         match_d      = 1'b0;
         overflow_d   = 1'b0;
         null_d       = 1'b0;
         done_d       = 1'b0;
      end else begin
         case (state_q)
            S_SCAN: begin
               // Window bounds are read live, so a moved end_addr applies to this very edge.
               if (entry_null_s) begin
                  state_d = S_MISS;
                  null_d  = 1'b1;
                  done_d  = 1'b1;
               end else if (rd_entry_s == word_q) begin
                  state_d      = S_FOUND;
                  match_d      = 1'b1;
                  match_addr_d = curr_addr_q;
                  done_d       = 1'b1;
               end else if (curr_addr_q == end_addr) begin
                  state_d    = S_MISS;
                  overflow_d = 1'b1;
                  done_d     = 1'b1;
               end else begin
                  curr_addr_d = curr_addr_q + ADDR_WIDTH'(1);
               end
            end
            S_IDLE, S_FOUND, S_MISS: begin
               state_d = state_q;
            end
            default: begin
               state_d = S_IDLE;
               done_d  = 1'b0;
            end
         endcase
      end
   end

   // State registers; synchronous reset also wipes the vocabulary.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            vocab_q[i] <= {W{1'b0}};
         end
         word_q       <= {W{1'b0}};
         state_q      <= S_IDLE;
         curr_addr_q  <= {ADDR_WIDTH{1'b0}};
         match_addr_q <= {ADDR_WIDTH{1'b0}};
         match_q      <= 1'b0;
         overflow_q   <= 1'b0;
         null_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            vocab_q[i] <= vocab_d[i];
         end
         word_q       <= word_d;
         state_q      <= state_d;
         curr_addr_q  <= curr_addr_d;
         match_addr_q <= match_addr_d;
         match_q      <= match_d;
         overflow_q   <= overflow_d;
         null_q       <= null_d;
         done_q       <= done_d;
      end
   end

   assign curr_addr      = curr_addr_q;
   assign match          = match_q;
   assign match_addr     = match_addr_q;
   assign vocab_overflow = overflow_q;
   assign nullptr_vocab  = null_q;
   assign done           = done_q;

endmodule

// File: tb/tb_matcher.sv
// Self-checking bench for matcher: directed scenarios plus randomized scans against a
// window-walking reference model.
module tb_matcher;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] word;
   logic [3:0]  start_addr;
   logic [3:0]  end_addr;
   logic        vocab_we;
   logic [3:0]  vocab_waddr;
   logic [23:0] vocab_wdata;
   logic [3:0]  curr_addr;
   logic        match;
   logic [3:0]  match_addr;
   logic        vocab_overflow;
   logic        nullptr_vocab;
   logic        done;

`ifdef MATCHER_NULL_TERM_EN
   localparam bit NULL_EN = 1'b1;
`else
   localparam bit NULL_EN = 1'b0;
`endif

   logic [23:0] mem [16];
   logic [23:0] wq;
   int          n_cmp = 0;
   int          n_err = 0;

   matcher dut (
      .clk(clk), .rst(rst), .word(word), .start_addr(start_addr), .end_addr(end_addr),
      .vocab_we(vocab_we), .vocab_waddr(vocab_waddr), .vocab_wdata(vocab_wdata),
      .curr_addr(curr_addr), .match(match), .match_addr(match_addr),
      .vocab_overflow(vocab_overflow), .nullptr_vocab(nullptr_vocab), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) mem[i] = 24'h0;
      wq = 24'h0;
   endtask

   task automatic vwrite(input logic [3:0] a, input logic [23:0] d);
      vocab_we    = 1'b1;
      vocab_waddr = a;
      vocab_wdata = d;
      step();
      vocab_we = 1'b0;
      mem[a]   = d;
      wq       = word;
   endtask

   task automatic trigger(input string tag, input logic [23:0] w, input logic [3:0] s,
                          input logic [3:0] e);
      start_addr = s;
      end_addr   = e;
      if (w != wq) begin
         word = w;
         step();
         wq = w;
      end else begin
         vwrite(4'd0, mem[0]);
      end
      chk({tag, "_trig_curr"}, 32'(curr_addr), 32'(s));
      chk({tag, "_trig_done"}, 32'(done), 32'd0);
      chk({tag, "_trig_flags"}, 32'({match, vocab_overflow, nullptr_vocab}), 32'd0);
      chk({tag, "_trig_maddr"}, 32'(match_addr), 32'd0);
   endtask

   // Reference: walk the window from start_addr, modulo 16, applying the outcome rules.
   task automatic finish_scan(input string tag);
      int          n;
      int          kind;
      logic [3:0]  a;
      logic [3:0]  last;
      bit          early;
      n = 0; kind = 0; last = 4'd0; early = 1'b0;
      for (int off = 0; off < 16; off++) begin
         a    = start_addr + 4'(off);
         n    = off + 1;
         last = a;
         if (NULL_EN && mem[a] == 24'h0) begin kind = 2; break; end
         if (mem[a] == wq)               begin kind = 1; break; end
         if (a == end_addr)              begin kind = 3; break; end
      end
      for (int i = 1; i < n; i++) begin
         step();
         if (done) early = 1'b1;
      end
      step();
      chk({tag, "_early"}, 32'(early), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_match"}, 32'(match), 32'(kind == 1));
      chk({tag, "_ovf"}, 32'(vocab_overflow), 32'(kind == 3));
      chk({tag, "_null"}, 32'(nullptr_vocab), 32'(kind == 2));
      chk({tag, "_curr"}, 32'(curr_addr), 32'(last));
      chk({tag, "_maddr"}, 32'(match_addr), (kind == 1) ? 32'(last) : 32'd0);
      step();
      chk({tag, "_hold"}, 32'({done, curr_addr}), 32'({1'b1, last}));
   endtask

   initial begin
      logic [23:0] d;
      logic [23:0] w;
      rst = 1'b1; word = 24'h0; start_addr = 4'd0; end_addr = 4'd15;
      vocab_we = 1'b0; vocab_waddr = 4'd0; vocab_wdata = 24'h0;
      model_clear();
      step(); step();
      rst = 1'b0;
      chk("rst_outs", 32'({curr_addr, match, match_addr, vocab_overflow, nullptr_vocab, done}), 32'd0);
      step(); step();
      chk("idle_no_scan", 32'({done, curr_addr}), 32'd0);

      vwrite(4'd0, 24'h48656C);
      vwrite(4'd1, 24'h414243);
      vwrite(4'd2, 24'h616263);
      trigger("hit1", 24'h414243, 4'd0, 4'd15);
      finish_scan("hit1");

      trigger("ovf3", 24'h5A5A5A, 4'd0, 4'd2);
      finish_scan("ovf3");

      trigger("full", 24'h5A5A5A, 4'd0, 4'd15);
      finish_scan("full");

      vwrite(4'd15, 24'h48656C);
      trigger("wrap_hit", 24'h48656C, 4'd14, 4'd1);
      finish_scan("wrap_hit");
      trigger("wrap_ovf", 24'h616263, 4'd14, 4'd1);
      finish_scan("wrap_ovf");

      trigger("one", 24'h616263, 4'd2, 4'd2);
      finish_scan("one");

      trigger("mid_a", 24'h5A5A5A, 4'd0, 4'd15);
      step(); step();
      trigger("mid_b", 24'h48656C, 4'd0, 4'd15);
      finish_scan("mid_b");

      trigger("rst_a", 24'h5A5A5A, 4'd0, 4'd15);
      step();
      rst = 1'b1;
      word = 24'h0;
      step();
      rst = 1'b0;
      model_clear();
      chk("rst_mid", 32'({curr_addr, match, match_addr, vocab_overflow, nullptr_vocab, done}), 32'd0);
      step(); step();
      chk("rst_idle", 32'({done, curr_addr}), 32'd0);
      trigger("rescan", 24'h48656C, 4'd0, 4'd15);
      finish_scan("rescan");

      for (int it = 0; it < 30; it++) begin
         for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
            d = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'(32'h414100 + $urandom_range(0, 7));
            vwrite(4'($urandom_range(0, 15)), d);
         end
         if ($urandom_range(0, 1) == 1) w = mem[$urandom_range(0, 15)];
         else w = 24'(32'h414100 + $urandom_range(0, 9));
         trigger("rnd", w, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         finish_scan("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
